// File: rtl/bit_scan_encoder.sv
// bit_scan_encoder: accepts a request vector and emits its set-bit indices as a
// stream of beats (strict one-hot, LSB-first or MSB-first scan), with error beats.
module bit_scan_encoder #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_err,
    output logic [OUT_W:0]   out_cnt
);
    if (WIDTH < 2 || WIDTH > 256 || (64'd1 << OUT_W) <= 64'(WIDTH)) begin : g_bad_params
        $error("bit_scan_encoder: illegal WIDTH/OUT_W combination");
    end
    typedef enum logic {IDLE, SCAN} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [1:0]       mode_q, mode_d;
    logic [OUT_W:0]   cnt_q, cnt_d, pop;
    logic [OUT_W-1:0] idx;
    logic             scan, strict, err, single, last;
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + (OUT_W+1)'(in_vec[i]);
    end
    // MSB-first keeps the last hit of an ascending walk; otherwise the last of a descending one.
    always_comb begin
        idx = '0;
        if (mode_q == 2'b10) begin
            for (int i = 0; i < WIDTH; i++) if (vec_q[i]) idx = OUT_W'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) if (vec_q[i]) idx = OUT_W'(i);
        end
    end
    always_comb begin
        scan   = state_q == SCAN;
        strict = mode_q == 2'b00;
        err    = cnt_q == '0 || (strict && cnt_q != (OUT_W+1)'(1));
        single = (vec_q & (vec_q - WIDTH'(1))) == '0;
        last   = err || strict || single;
        state_d = state_q;
        vec_d   = vec_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        if (!scan && in_valid) begin
            state_d = SCAN;
            vec_d   = in_vec;
            mode_d  = in_mode;
            cnt_d   = pop;
        end else if (scan && out_ready) begin
            state_d = last ? IDLE : SCAN;
            vec_d   = last ? '0 : vec_q & ~(WIDTH'(1) << idx);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end
    assign in_ready  = !scan;
    assign out_valid = scan;
    assign out_idx   = scan ? (err ? '1 : idx) : '0;
    assign out_last  = scan && last;
    assign out_err   = scan && err;
    assign out_cnt   = cnt_q;
endmodule

// File: doc/bit_scan_encoder.md
BIT_SCAN_ENCODER -- requirements
Module: bit_scan_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning input vector width, legal range 2..256.
REQ-002 SHALL have parameter OUT_W, default 8, meaning index output width; a WIDTH/OUT_W pair with 2**OUT_W <= WIDTH SHALL be rejected at elaboration.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  in_vec/in_mode present.
REQ-006 SHALL have port in_ready  output  1  block can accept a vector.
REQ-007 SHALL have port in_vec  input  WIDTH  request vector, bit i = request i.
REQ-008 SHALL have port in_mode  input  2  00 strict one-hot, 01 scan LSB-first, 10 scan MSB-first, 11 reserved (treated as 01).
REQ-009 SHALL have port out_valid  output  1  beat on out_idx is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts beat.
REQ-011 SHALL have port out_idx  output  OUT_W  zero-extended bit index, all-ones on error.
REQ-012 SHALL have port out_last  output  1  final beat of current vector.
REQ-013 SHALL have port out_err  output  1  vector invalid for its mode.
REQ-014 SHALL have port out_cnt  output  OUT_W+1  popcount of accepted vector, held for all beats.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and SCAN; in_ready = (state == IDLE), no combinational path from out_ready to in_ready.
REQ-016 SHALL accept a vector when in_valid && in_ready at a rising edge, registering in_vec, in_mode and popcount, and move to SCAN.
REQ-017 SHALL assert out_valid the cycle after acceptance (latency 1) and keep it high in SCAN until the last beat is taken.
REQ-018 SHALL hold out_idx, out_last, out_err, out_cnt stable while out_valid && !out_ready.
REQ-019 Scan modes: each beat SHALL present the lowest (01/11) or highest (10) set bit of the remaining vector; on out_valid && out_ready that bit SHALL be cleared.
REQ-020 Scan modes: out_last SHALL be 1 exactly when one set bit remains; taking that beat SHALL return the FSM to IDLE.
REQ-021 Strict mode with exactly one bit set: one beat, out_idx = bit position, out_err = 0, out_last = 1.
REQ-022 Strict mode with popcount != 1, or any mode with in_vec == 0: one beat, out_idx = all-ones, out_err = 1, out_last = 1.
REQ-023 out_err SHALL be 0 on every beat of a non-zero scan-mode vector.
REQ-024 Accepted vector of N set bits in scan mode SHALL produce exactly N beats; with out_ready held high, one beat per cycle.
REQ-025 Taking the last beat SHALL leave in_ready high the following cycle (one-cycle bubble between vectors); in_vec changes while in SCAN SHALL be ignored.
REQ-026 out_cnt SHALL equal popcount of in_vec as accepted, including 0 and WIDTH.
REQ-027 Bit WIDTH-1 set SHALL encode to WIDTH-1, never aliasing the error code.

Reset
REQ-028 On rst high, asynchronously: state = IDLE, out_valid = 0, out_last = 0, out_err = 0, out_idx = 0, out_cnt = 0, internal vector = 0.
REQ-029 in_ready SHALL be 1 after reset.
REQ-030 Reset asserted mid-SCAN SHALL discard remaining beats; no beat for that vector after release.
REQ-031 in_valid asserted during or in the same edge as rst release SHALL NOT be accepted until the first edge with rst low.

Verification
REQ-032 WIDTH=16, mode 00, in_vec=0x0100, out_ready=1 -> one beat idx=8, err=0, last=1, cnt=1; in_ready high next cycle.
REQ-033 Mode 00, in_vec=0x0101 -> one beat idx=0xFF, err=1, last=1, cnt=2; mode 01, in_vec=0x0000 -> idx=0xFF, err=1, cnt=0.
REQ-034 Mode 01, in_vec=0x8421, out_ready=1 -> beats idx 0,5,10,15 on consecutive cycles, last only on 15, cnt=4; mode 10 same vector -> 15,10,5,0.
REQ-035 Mode 01, in_vec=0x0006, out_ready low 3 cycles -> idx=1 held stable with out_valid=1; on out_ready high -> 1 then 2 (last).
REQ-036 Mode 10, in_vec=0xFFFF, rst pulsed after 5 beats -> outputs cleared immediately, in_ready=1, no further beats; next vector 0x0004 mode 00 -> idx=2.
REQ-037 Random in_vec/in_mode/out_ready backpressure, 10k vectors -> beat sequence matches a reference scoreboard, no lost or duplicate beats.
